// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle between the interconnect and one SRAM-backed slave.
// Handshake: an address phase is taken on a rising edge with HSEL & HREADY & HTRANS[1];
// its data phase ends on the first rising edge with HREADYOUT=1, where HRDATA/HRESP are valid.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a single-port synchronous SRAM: programmable wait states,
// byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 16384,
  parameter int SRAM_AW     = 14
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_sram_slave_if.slave    bus,
  output logic               SRAM_CS,
  output logic [3:0]         SRAM_WE,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic [31:0]        SRAM_DI,
  input  logic [31:0]        SRAM_DO,
  output logic [2:0]         state_dbg_o
);

  localparam int CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_STATES + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [3:0]         lanes_q, lanes_d;

  logic       accept;
  logic       illegal;
  logic [3:0] lane_mask;
  logic       wr_final;
  logic       rd_final;
  logic       rd_strobe;
  logic       final_cycle;

  always_comb begin
    accept  = bus.HSEL && bus.HREADY && ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
    illegal = (bus.HSIZE > 3'd2)
           || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
           || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
           || ({2'b00, bus.HADDR[31:2]} >= 32'(MEM_WORDS));
    case (bus.HSIZE)
      3'd0:    lane_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1:    lane_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // The read strobe is issued in the first RD cycle, so RD loads one extra count.
  always_comb begin
    wr_final    = (state_q == ST_WR) && (cnt_q == '0);
    rd_final    = (state_q == ST_RD) && (cnt_q == '0);
    rd_strobe   = (state_q == ST_RD) && (cnt_q == RD_LOAD);
    final_cycle = (state_q == ST_IDLE) || wr_final || rd_final || (state_q == ST_ERR2);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    if (final_cycle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (accept) begin
        addr_d  = bus.HADDR[SRAM_AW+1:2];
        lanes_d = lane_mask;
        if (illegal) begin
          state_d = ST_ERR1;
        end else if (bus.HWRITE) begin
          state_d = ST_WR;
          cnt_d   = WR_LOAD;
        end else begin
          state_d = ST_RD;
          cnt_d   = RD_LOAD;
        end
      end
    end else begin
      case (state_q)
        ST_WR, ST_RD: cnt_d = cnt_q - CNT_W'(1);
        ST_ERR1:      state_d = ST_ERR2;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
    end
  end

  // All outputs decode from registered state so reset clears them without a clock.
  assign bus.HREADYOUT = final_cycle;
  assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign bus.HRDATA    = rd_final ? SRAM_DO : 32'h0;
  assign SRAM_CS       = wr_final || rd_strobe;
  assign SRAM_WE       = wr_final ? lanes_q : 4'b0000;
  assign SRAM_A        = SRAM_CS ? addr_q : '0;
  assign SRAM_DI       = wr_final ? bus.HWDATA : 32'h0;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves (0 and 2 wait states) on a small AHB fabric, driven by pipelined
// directed and random transfers, checked against a byte-lane memory model.
module tb_ahb_sram_slave;
  localparam int WORDS0 = 16384;
  localparam int WORDS2 = 1000;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        tgt;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t txq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cs0 = 0;
  int   exp_cs2 = 0;
  int   cs_cnt0 = 0;
  int   cs_cnt2 = 0;

  logic        tgt;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        dp_tgt;
  logic        bus_hready;
  logic        bus_hresp;
  logic [31:0] bus_hrdata;

  logic        cs0, cs2;
  logic [3:0]  we0, we2;
  logic [13:0] a0;
  logic [9:0]  a2;
  logic [31:0] di0, di2;
  logic [31:0] do0 = 32'h0;
  logic [31:0] do2 = 32'h0;
  logic [2:0]  st0, st2;

  logic [31:0] mem0 [WORDS0] = '{default: '0};
  logic [31:0] mem2 [1024]   = '{default: '0};
  logic [31:0] ref0 [WORDS0] = '{default: '0};
  logic [31:0] ref2 [WORDS2] = '{default: '0};

  ahb_sram_slave_if if0 ();
  ahb_sram_slave_if if2 ();

  assign if0.HSEL   = (tgt == 1'b0);
  assign if2.HSEL   = (tgt == 1'b1);
  assign if0.HADDR  = haddr;
  assign if2.HADDR  = haddr;
  assign if0.HTRANS = htrans;
  assign if2.HTRANS = htrans;
  assign if0.HWRITE = hwrite;
  assign if2.HWRITE = hwrite;
  assign if0.HSIZE  = hsize;
  assign if2.HSIZE  = hsize;
  assign if0.HWDATA = hwdata;
  assign if2.HWDATA = hwdata;
  assign if0.HREADY = bus_hready;
  assign if2.HREADY = bus_hready;

  // Interconnect response mux follows whichever slave owns the current data phase.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_tgt <= 1'b0;
    else if (bus_hready) dp_tgt <= tgt;
  end
  assign bus_hready = dp_tgt ? if2.HREADYOUT : if0.HREADYOUT;
  assign bus_hresp  = dp_tgt ? if2.HRESP : if0.HRESP;
  assign bus_hrdata = dp_tgt ? if2.HRDATA : if0.HRDATA;

  ahb_sram_slave #(.WAIT_STATES(0), .MEM_WORDS(WORDS0), .SRAM_AW(14)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if0),
    .SRAM_CS(cs0), .SRAM_WE(we0), .SRAM_A(a0), .SRAM_DI(di0), .SRAM_DO(do0),
    .state_dbg_o(st0)
  );

  ahb_sram_slave #(.WAIT_STATES(2), .MEM_WORDS(WORDS2), .SRAM_AW(10)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if2),
    .SRAM_CS(cs2), .SRAM_WE(we2), .SRAM_A(a2), .SRAM_DI(di2), .SRAM_DO(do2),
    .state_dbg_o(st2)
  );

  // SRAM macro models plus strobe counters.
  always @(posedge HCLK) begin
    if (cs0) begin
      cs_cnt0 <= cs_cnt0 + 1;
      if (we0 == 4'b0000) do0 <= mem0[a0];
      else for (int b = 0; b < 4; b++) if (we0[b]) mem0[a0][8*b +: 8] <= di0[8*b +: 8];
    end
    if (cs2) begin
      cs_cnt2 <= cs_cnt2 + 1;
      if (we2 == 4'b0000) do2 <= mem2[a2];
      else for (int b = 0; b < 4; b++) if (we2[b]) mem2[a2][8*b +: 8] <= di2[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int words_of(input logic t);
    return t ? WORDS2 : WORDS0;
  endfunction

  function automatic bit is_illegal(input txn_t t);
    return (t.size > 2) || (t.size == 1 && (t.addr % 2) != 0) ||
           (t.size == 2 && (t.addr % 4) != 0) || ((t.addr / 4) >= words_of(t.tgt));
  endfunction

  function automatic int exp_len(input txn_t t);
    if (is_illegal(t)) return 2;
    return (t.wr ? 1 : 2) + (t.tgt ? 2 : 0);
  endfunction

  function automatic logic [3:0] mask_of(input txn_t t);
    logic [3:0] m = 4'b0000;
    for (int k = 0; k < (1 << t.size); k++) m[(t.addr % 4) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_read(input txn_t t);
    return t.tgt ? ref2[t.addr / 4] : ref0[t.addr / 4];
  endfunction

  task automatic ref_write(input txn_t t);
    logic [3:0] m = mask_of(t);
    for (int b = 0; b < 4; b++) begin
      if (m[b] && t.tgt) ref2[t.addr / 4][8*b +: 8] = t.wdata[8*b +: 8];
      if (m[b] && !t.tgt) ref0[t.addr / 4][8*b +: 8] = t.wdata[8*b +: 8];
    end
  endtask

  task automatic push(input logic t, input logic w, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    txn_t x;
    x.tgt = t; x.wr = w; x.size = s; x.addr = a; x.wdata = d;
    txq.push_back(x);
  endtask

  task automatic check_done(input txn_t p, input int cycles, input int bad_resp,
                            input logic [31:0] rd, input logic cs, input logic [3:0] we,
                            input logic [31:0] a, input logic [31:0] di);
    chk("phase_len", cycles, exp_len(p));
    chk("resp_cycles_wrong", bad_resp, 0);
    if (is_illegal(p)) begin
      chk("err_rdata", rd, 32'h0);
    end else if (p.wr) begin
      chk("wr_cs", cs, 1);
      chk("wr_we", we, mask_of(p));
      chk("wr_addr", a, p.addr / 4);
      chk("wr_di", di, p.wdata);
      chk("wr_rdata", rd, 32'h0);
      ref_write(p);
      if (p.tgt) exp_cs2++; else exp_cs0++;
    end else begin
      chk("rd_data", rd, ref_read(p));
      if (p.tgt) exp_cs2++; else exp_cs0++;
    end
  endtask

  // Drives the queued transfers back to back: address phase i overlaps data phase i-1.
  task automatic run_seq();
    int n = txq.size();
    int cycles, bad_resp;
    logic rdy, cs;
    logic [3:0] we;
    logic [31:0] rd, a, di;
    txn_t p, c;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        c = txq[i];
        tgt = c.tgt; htrans = 2'b10; haddr = c.addr; hwrite = c.wr; hsize = c.size;
      end else begin
        htrans = 2'b00;
      end
      if (i > 0) begin
        p = txq[i-1];
        hwdata = p.wdata;
      end
      cycles = 0; bad_resp = 0;
      rd = '0; cs = 1'b0; we = '0; a = '0; di = '0;
      do begin
        @(negedge HCLK);
        cycles++;
        rdy = bus_hready;
        if (i > 0) begin
          rd = bus_hrdata;
          if (bus_hresp !== is_illegal(p)) bad_resp++;
          cs = p.tgt ? cs2 : cs0;
          we = p.tgt ? we2 : we0;
          a  = p.tgt ? 32'(a2) : 32'(a0);
          di = p.tgt ? di2 : di0;
        end
      end while (!rdy && cycles < 20);
      chk("hready_within_budget", rdy, 1);
      if (!rdy) begin
        txq.delete();
        return;
      end
      if (i > 0) check_done(p, cycles, bad_resp, rd, cs, we, a, di);
      @(posedge HCLK);
      #1;
    end
    txq.delete();
  endtask

  task automatic reset_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    tgt = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = 3'd2;
    @(negedge HCLK);
    chk("rm_accept_ready", bus_hready, 1);
    @(posedge HCLK);
    #1;
    htrans = 2'b00; hwdata = wdata;
    @(negedge HCLK);
    chk("rm_c1_ready", if2.HREADYOUT, 0);
    chk("rm_c1_cs", cs2, !wr);
    @(negedge HCLK);
    chk("rm_c2_ready", if2.HREADYOUT, 0);
    HRESETn = 1'b0;
    #1;
    chk("rm_rst_ready", if2.HREADYOUT, 1);
    chk("rm_rst_resp", if2.HRESP, 0);
    chk("rm_rst_cs", cs2, 0);
    chk("rm_rst_we", we2, 0);
    chk("rm_rst_rdata", if2.HRDATA, 0);
    chk("rm_rst_state", st2, 0);
    if (!wr) exp_cs2++;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    txn_t r;
    int base, word, sel;
    tgt = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ready0", if0.HREADYOUT, 1);
    chk("rst_resp0", if0.HRESP, 0);
    chk("rst_rdata0", if0.HRDATA, 0);
    chk("rst_cs0", cs0, 0);
    chk("rst_we0", we0, 0);
    chk("rst_a0", a0, 0);
    chk("rst_di0", di0, 0);
    chk("rst_state0", st0, 0);
    chk("rst_ready2", if2.HREADYOUT, 1);
    chk("rst_cs2", cs2, 0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait slave: word write/read, then sub-word merges into the same word.
    push(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    push(0, 0, 3'd2, 32'h10, 32'h0);
    push(0, 1, 3'd0, 32'h13, 32'hA5000000);
    push(0, 1, 3'd1, 32'h10, 32'h00001234);
    push(0, 0, 3'd2, 32'h10, 32'h0);
    run_seq();
    chk("merged_word", ref0[4], 32'hA5AD1234);

    // Illegal accesses: misaligned, out of range, bad size; memory must be untouched.
    push(0, 1, 3'd1, 32'h11, 32'h11111111);
    push(0, 1, 3'd2, 32'h12, 32'h22222222);
    push(0, 1, 3'd2, WORDS0 * 4, 32'h33333333);
    push(0, 1, 3'd3, 32'h10, 32'h44444444);
    push(0, 0, 3'd2, 32'h10, 32'h0);
    run_seq();
    chk("cs_count0_after_err", cs_cnt0, exp_cs0);

    // Two-wait-state slave: pipelined write/read/write, boundary words, cross-slave mix.
    push(1, 1, 3'd2, 32'h40, 32'hCAFEF00D);
    push(1, 0, 3'd2, 32'h40, 32'h0);
    push(1, 1, 3'd2, 32'h44, 32'h0BADC0DE);
    push(1, 1, 3'd2, (WORDS2 - 1) * 4, 32'h76543210);
    push(1, 0, 3'd2, (WORDS2 - 1) * 4, 32'h0);
    push(1, 0, 3'd2, WORDS2 * 4, 32'h0);
    push(0, 0, 3'd2, 32'h10, 32'h0);
    push(1, 0, 3'd0, 32'h45, 32'h0);
    push(0, 1, 3'd1, 32'h12, 32'hBEEF0000);
    push(1, 0, 3'd2, 32'h44, 32'h0);
    run_seq();
    chk("cs_count2", cs_cnt2, exp_cs2);

    // Reset during a write wait cycle and during a read wait cycle.
    reset_mid(1'b1, 32'h40, 32'h99999999);
    reset_mid(1'b0, 32'h40, 32'h0);
    push(1, 0, 3'd2, 32'h40, 32'h0);
    run_seq();
    chk("after_reset_word", ref2[16], 32'hCAFEF00D);

    for (int k = 0; k < 60; k++) begin
      r.tgt = 1'($urandom_range(0, 1));
      r.wr = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      r.size = (sel == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      base = r.tgt ? (WORDS2 - 8) : (WORDS0 - 8);
      word = base + $urandom_range(0, 7) + ((sel == 1) ? 8 : 0);
      r.addr = word * 4 + $urandom_range(0, 3);
      r.wdata = $urandom;
      txq.push_back(r);
    end
    run_seq();
    chk("final_cs0", cs_cnt0, exp_cs0);
    chk("final_cs2", cs_cnt2, exp_cs2);
    chk("final_state0", st0, 0);
    chk("final_state2", st2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
